// File: rtl/sad_row_sequencer.sv
// Sequences the vertical SAD processor through a full template search:
// per image row position, clear PEs, fetch rows, stream template, settle, sample.
module sad_row_sequencer #(
   parameter int unsigned TPL_W   = 40,
   parameter int unsigned TPL_H   = 40,
   parameter int unsigned IMG_H   = 480,
   parameter int unsigned SETTLE  = 2,
   parameter int unsigned COORD_W = 10,
   localparam int unsigned AW     = $clog2(TPL_W * TPL_H)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               match_found,
   output logic [8:0]         match_row,
   output logic [COORD_W-1:0] match_col,
   output logic               img_row_req,
   output logic [8:0]         img_row_idx,
   input  logic               img_row_ack,
   output logic               tpl_rd,
   output logic [AW-1:0]      tpl_addr,
   input  logic               tpl_pixel,
   output logic               pe_clear,
   output logic               pe_en,
   output logic               pe_template,
   output logic               control_change_row,
   input  logic               sad_status,
   input  logic [COORD_W-1:0] coordinate
);

   localparam int unsigned CW = $clog2(TPL_W + 1);
   localparam int unsigned TW = (TPL_H > 1) ? $clog2(TPL_H) : 1;
   localparam int unsigned SW = $clog2(SETTLE + 1);

   localparam logic [2:0] StIdle      = 3'd0;
   localparam logic [2:0] StClear     = 3'd1;
   localparam logic [2:0] StRowReq    = 3'd2;
   localparam logic [2:0] StStream    = 3'd3;
   localparam logic [2:0] StChangeRow = 3'd4;
   localparam logic [2:0] StSettle    = 3'd5;
   localparam logic [2:0] StSample    = 3'd6;
   localparam logic [2:0] StDone      = 3'd7;

   logic [2:0]         state_q, state_d;
   logic [8:0]         r_q, r_d;
   logic [TW-1:0]      t_q, t_d;
   logic [CW-1:0]      c_q, c_d;
   logic [SW-1:0]      s_q, s_d;
   logic               match_found_q, match_found_d;
   logic [8:0]         match_row_q, match_row_d;
   logic [COORD_W-1:0] match_col_q, match_col_d;

   always_comb begin
      state_d       = state_q;
      r_d           = r_q;
      t_d           = t_q;
      c_d           = c_q;
      s_d           = s_q;
      match_found_d = match_found_q;
      match_row_d   = match_row_q;
      match_col_d   = match_col_q;
      // abort wins over everything, including start while idle
      if (abort) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_d       = StClear;
                  r_d           = '0;
                  match_found_d = 1'b0;
                  match_row_d   = '0;
                  match_col_d   = '0;
               end
            end
            StClear: begin
               t_d     = '0;
               state_d = StRowReq;
            end
            StRowReq: begin
               if (img_row_ack) begin
                  c_d     = '0;
                  state_d = StStream;
               end
            end
            StStream: begin
               if (c_q == CW'(TPL_W)) state_d = StChangeRow;
               else                   c_d     = c_q + 1'b1;
            end
            StChangeRow: begin
               if (t_q == TW'(TPL_H - 1)) begin
                  s_d     = '0;
                  state_d = StSettle;
               end else begin
                  t_d     = t_q + 1'b1;
                  state_d = StRowReq;
               end
            end
            StSettle: begin
               if (s_q == SW'(SETTLE - 1)) state_d = StSample;
               else                        s_d     = s_q + 1'b1;
            end
            StSample: begin
               if (sad_status) begin
                  match_found_d = 1'b1;
                  match_row_d   = r_q;
                  match_col_d   = coordinate;
                  state_d       = StDone;
               end else if (r_q == 9'(IMG_H - TPL_H)) begin
                  state_d = StDone;
               end else begin
                  r_d     = r_q + 1'b1;
                  state_d = StClear;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         r_q           <= '0;
         t_q           <= '0;
         c_q           <= '0;
         s_q           <= '0;
         match_found_q <= 1'b0;
         match_row_q   <= '0;
         match_col_q   <= '0;
      end else begin
         state_q       <= state_d;
         r_q           <= r_d;
         t_q           <= t_d;
         c_q           <= c_d;
         s_q           <= s_d;
         match_found_q <= match_found_d;
         match_row_q   <= match_row_d;
         match_col_q   <= match_col_d;
      end
   end

   always_comb begin
      busy               = (state_q != StIdle);
      done               = (state_q == StDone);
      pe_clear           = (state_q == StClear);
      control_change_row = (state_q == StChangeRow);
      img_row_req        = (state_q == StRowReq);
      img_row_idx        = img_row_req ? (r_q + 9'(t_q)) : '0;
      tpl_rd             = (state_q == StStream) && (c_q < CW'(TPL_W));
      tpl_addr           = tpl_rd ? AW'(32'(t_q) * TPL_W + 32'(c_q)) : '0;
      // RAM data lags the read strobe by one cycle, so the PE enable does too
      pe_en              = (state_q == StStream) && (c_q != '0);
      pe_template        = pe_en & tpl_pixel;
      match_found        = match_found_q;
      match_row          = match_row_q;
      match_col          = match_col_q;
   end

endmodule

// File: tb/tb_sad_row_sequencer.sv
// Bench for sad_row_sequencer: a per-cycle expected-output trace built from the
// search rules, compared every cycle, plus hand-computed literal expectations.
module tb_sad_row_sequencer;

   localparam int W = 4;
   localparam int H = 2;
   localparam int IH = 4;
   localparam int ST = 2;

   logic       clk = 1'b0;
   logic       rst, start, abort, img_row_ack, tpl_pixel, sad_status;
   logic [9:0] coordinate;
   logic       busy, done, match_found, img_row_req, tpl_rd;
   logic       pe_clear, pe_en, pe_template, control_change_row;
   logic [8:0] match_row, img_row_idx;
   logic [9:0] match_col;
   logic [2:0] tpl_addr;

   sad_row_sequencer #(
      .TPL_W(W), .TPL_H(H), .IMG_H(IH), .SETTLE(ST), .COORD_W(10)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .match_found(match_found), .match_row(match_row), .match_col(match_col),
      .img_row_req(img_row_req), .img_row_idx(img_row_idx), .img_row_ack(img_row_ack),
      .tpl_rd(tpl_rd), .tpl_addr(tpl_addr), .tpl_pixel(tpl_pixel), .pe_clear(pe_clear),
      .pe_en(pe_en), .pe_template(pe_template), .control_change_row(control_change_row),
      .sad_status(sad_status), .coordinate(coordinate)
   );

   always #5 clk = ~clk;

   // template RAM contents at addresses 0..7: 1,0,1,1,0,0,1,0
   logic [7:0] pat = 8'b0100_1101;
   always @(posedge clk) tpl_pixel <= tpl_rd ? pat[tpl_addr] : 1'b0;

   typedef struct packed {
      logic       busy, done, req;
      logic [8:0] idx;
      logic       rd;
      logic [2:0] addr;
      logic       clr, en, tpl, ccr;
   } outs_t;

   typedef struct {
      outs_t o;
      logic  ack, sad, abort, start;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   obs_idx[$], obs_addr[$], obs_tpl[$];
   int   done_at;

   task automatic check_v(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic check_seq(input string name, input int got[$], input int exp[$]);
      check_v({name, "_len"}, 64'(got.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check_v($sformatf("%s[%0d]", name, i), 64'(got[i]), 64'(exp[i]));
   endtask

   task automatic add(input outs_t o, input logic a, input logic s);
      ent_t e;
      e.o = o; e.ack = a; e.sad = s; e.abort = 1'b0; e.start = 1'b0;
      q.push_back(e);
   endtask

   // Expected trace of one search, starting the cycle after start is accepted.
   task automatic build(input int match_r, input int dly);
      outs_t o;
      q.delete();
      for (int r = 0; r <= IH - H; r++) begin
         o = '0; o.busy = 1'b1; o.clr = 1'b1; add(o, 1'b0, 1'b0);
         for (int t = 0; t < H; t++) begin
            for (int d = 0; d <= dly; d++) begin
               o = '0; o.busy = 1'b1; o.req = 1'b1; o.idx = 9'(r + t);
               add(o, d == dly, 1'b0);
            end
            for (int c = 0; c <= W; c++) begin
               o = '0; o.busy = 1'b1;
               o.rd   = (c < W);
               o.addr = (c < W) ? 3'(t * W + c) : 3'd0;
               o.en   = (c > 0);
               o.tpl  = (c > 0) ? pat[t * W + c - 1] : 1'b0;
               add(o, 1'b0, 1'b0);
            end
            o = '0; o.busy = 1'b1; o.ccr = 1'b1; add(o, 1'b0, 1'b0);
         end
         for (int s = 0; s < ST; s++) begin
            o = '0; o.busy = 1'b1; add(o, 1'b0, 1'b0);
         end
         o = '0; o.busy = 1'b1; add(o, 1'b0, r == match_r);
         if (r == match_r) break;
      end
      o = '0; o.busy = 1'b1; o.done = 1'b1; add(o, 1'b0, 1'b0);
      o = '0; add(o, 1'b0, 1'b0);
   endtask

   function automatic outs_t sample_dut();
      outs_t a;
      a.busy = busy; a.done = done; a.req = img_row_req;
      a.idx  = img_row_req ? img_row_idx : 9'd0;
      a.rd   = tpl_rd;
      a.addr = tpl_rd ? tpl_addr : 3'd0;
      a.clr  = pe_clear; a.en = pe_en;
      a.tpl  = pe_en ? pe_template : 1'b0;
      a.ccr  = control_change_row;
      return a;
   endfunction

   function automatic logic [63:0] all_outs();
      return 64'({busy, done, match_found, match_row, match_col, img_row_req, img_row_idx,
                  tpl_rd, tpl_addr, pe_clear, pe_en, pe_template, control_change_row});
   endfunction

   // Called #1 after a rising edge; returns in the same phase.
   task automatic run(input string tag, input int n, input logic do_start);
      outs_t a;
      obs_idx.delete(); obs_addr.delete(); obs_tpl.delete();
      done_at = -1;
      if (do_start) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int i = 0; i < n && i < q.size(); i++) begin
         img_row_ack = q[i].ack; sad_status = q[i].sad;
         abort = q[i].abort; start = q[i].start;
         @(negedge clk);
         a = sample_dut();
         check_v($sformatf("%s_cyc%0d", tag, i), 64'(a), 64'(q[i].o));
         if (img_row_req && img_row_ack) obs_idx.push_back(int'(img_row_idx));
         if (tpl_rd) obs_addr.push_back(int'(tpl_addr));
         if (pe_en) obs_tpl.push_back(int'(pe_template));
         if (done && done_at < 0) done_at = i;
         @(posedge clk); #1;
      end
      img_row_ack = 1'b0; sad_status = 1'b0; abort = 1'b0; start = 1'b0;
   endtask

   int e_idx[$] = '{0, 1, 1, 2, 2, 3};
   int e_addr[$];
   int e_tpl[$];
   int e_tpl1[$] = '{1, 0, 1, 1, 0, 0, 1, 0};

   initial begin
      for (int p = 0; p < 3; p++)
         for (int a = 0; a < 8; a++) begin
            e_addr.push_back(a);
            e_tpl.push_back(e_tpl1[a]);
         end
      rst = 1'b1; start = 1'b0; abort = 1'b0; img_row_ack = 1'b0;
      sad_status = 1'b0; coordinate = 10'd37;
      repeat (2) @(posedge clk);
      #1 check_v("reset_outputs", all_outs(), 64'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // no match, immediate ack: 3 positions of 18 cycles, then DONE
      build(-1, 0);
      check_v("model_len_nomatch", 64'(q.size()), 64'd56);
      run("nomatch", q.size(), 1'b1);
      check_v("nomatch_done_at", 64'(done_at), 64'd54);
      check_v("nomatch_found", 64'(match_found), 64'd0);
      check_seq("nomatch_idx", obs_idx, e_idx);
      check_seq("nomatch_addr", obs_addr, e_addr);
      check_seq("nomatch_tpl", obs_tpl, e_tpl);

      // ack held low 5 cycles per request: +5 per each of 6 requests
      build(-1, 5);
      run("slowack", q.size(), 1'b1);
      check_v("slowack_done_at", 64'(done_at), 64'd84);
      check_seq("slowack_idx", obs_idx, e_idx);

      // match at the 2nd sample: done 18 cycles earlier than the no-match run
      build(1, 0);
      check_v("model_len_match", 64'(q.size()), 64'd38);
      run("match", q.size(), 1'b1);
      check_v("match_done_at", 64'(done_at), 64'd36);
      check_v("match_found", 64'(match_found), 64'd1);
      check_v("match_row", 64'(match_row), 64'd1);
      check_v("match_col", 64'(match_col), 64'd37);

      // abort mid-stream of position 1 (cycle 22 = STREAM c=2)
      build(-1, 0);
      while (q.size() > 23) void'(q.pop_back());
      q[22].abort = 1'b1;
      begin
         outs_t o;
         o = '0;
         add(o, 1'b0, 1'b0);
         add(o, 1'b0, 1'b0);
      end
      run("abort", 1, 1'b1);
      check_v("restart_match_cleared", 64'({match_found, match_row, match_col}), 64'd0);
      begin
         ent_t rest[$];
         rest = q[1:$];
         q = rest;
      end
      run("abort_rest", q.size(), 1'b0);
      check_v("abort_no_done", 64'(done_at), 64'hFFFF_FFFF_FFFF_FFFF);
      check_v("abort_all_low", all_outs(), 64'd0);

      // start while busy is ignored
      build(-1, 0);
      q[5].start = 1'b1;
      q[30].start = 1'b1;
      run("busystart", q.size(), 1'b1);
      check_v("busystart_done_at", 64'(done_at), 64'd54);
      check_seq("busystart_idx", obs_idx, e_idx);

      // asynchronous reset in SETTLE of position 0 (cycle 15)
      build(1, 0);
      run("rstrun", 15, 1'b1);
      check_v("pre_rst_busy", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1 check_v("async_rst_outputs", all_outs(), 64'd0);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_v("post_rst_idle", all_outs(), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
